keccak_arbiter: RTL and testbench

Shares one `keccak` hashing core between `NREQ` independent message sources, granting the core to one requester for a whole message at a time. Sits between requester streams and the core: clears the core before each message, forwards 32-bit words with the core's backpressure, waits for the digest and returns it tagged with the owner's index. Arbitration is round-robin at message granularity. A message is never interleaved with another.

---
 rtl/keccak_arb_pkg.sv | 14 +
 rtl/keccak_rr_pick.sv | 32 +++
 rtl/keccak_arbiter.sv | 160 ++++++++++++++++
 tb/tb_keccak_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_arb_pkg.sv
// Shared types and widths for the keccak core arbiter.
package keccak_arb_pkg;
  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 512;
  localparam int BNUM_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_WAIT,
    ST_DONE
  } arb_state_e;
endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module keccak_rr_pick
  import keccak_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j         = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = |req_i;
    // Walk from the farthest offset down so the closest request to ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (req_i[j]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Message-granular round-robin arbiter sharing one keccak core among NREQ sources.
// Optional stall timeout is enabled by defining KECCAK_ARB_TIMEOUT_EN.
module keccak_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*BNUM_W-1:0]   req_byte_num,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [DIGEST_W-1:0]      rsp_digest,
  output logic                     rsp_err,
  output logic                     core_reset,
  output logic [WORD_W-1:0]        core_in,
  output logic                     core_in_ready,
  output logic                     core_is_last,
  output logic [BNUM_W-1:0]        core_byte_num,
  input  logic                     core_buffer_full,
  input  logic [DIGEST_W-1:0]      core_out,
  input  logic                     core_out_ready
);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [IDW-1:0]      next_ptr;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic [NREQ-1:0]     unused_pick_oh;

  keccak_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (unused_pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign next_ptr = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign rsp_err    = err_q;
  // The abort cycle also clears the core so the half-absorbed message is discarded.
  assign core_reset = !reset || (state_q == ST_CLEAR) || err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign rsp_err    = 1'b0;
  assign core_reset = !reset || (state_q == ST_CLEAR);
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    rsp_id_d      = rsp_id_q;
    digest_d      = digest_q;
    req_ready     = '0;
    core_in_ready = 1'b0;
    core_in       = '0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    rsp_valid     = (state_q == ST_DONE);
`ifdef KECCAK_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
`ifdef KECCAK_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_STREAM: begin
        core_in_ready      = req_valid[grant_q];
        core_in            = req_data[WORD_W*int'(grant_q) +: WORD_W];
        core_is_last       = req_last[grant_q];
        core_byte_num      = req_byte_num[BNUM_W*int'(grant_q) +: BNUM_W];
        req_ready[grant_q] = !core_buffer_full;
        if (req_valid[grant_q] && !core_buffer_full && req_last[grant_q]) state_d = ST_WAIT;
`ifdef KECCAK_ARB_TIMEOUT_EN
        // Only an absent word counts as a stall; core backpressure does not.
        if (req_valid[grant_q]) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          rsp_id_d = grant_q;
          ptr_d    = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      ST_WAIT: begin
        if (core_out_ready) begin
          digest_d = core_out;
          rsp_id_d = grant_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = next_ptr;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      digest_q <= digest_d;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_digest = digest_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter with a behavioural order-sensitive core stand-in.
module tb_keccak_arbiter;
  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int TMO     = 16;
  localparam int BUDGET  = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*2-1:0] req_byte_num;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [511:0]      rsp_digest;
  logic              rsp_err;
  logic              core_reset;
  logic [31:0]       core_in;
  logic              core_in_ready;
  logic              core_is_last;
  logic [1:0]        core_byte_num;
  logic              core_buffer_full;
  logic [511:0]      core_out;
  logic              core_out_ready;

  keccak_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_byte_num(req_byte_num), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_digest(rsp_digest), .rsp_err(rsp_err),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out), .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  // Core stand-in: rotate-xor absorb, word count folded into digest, 4-cycle latency.
  logic [511:0] c_acc;
  logic [31:0]  c_cnt;
  logic         c_got_last;
  int           c_lat;
  assign core_out = c_acc ^ {c_cnt, 480'b0};

  always @(posedge clk) begin
    if (core_reset) begin
      c_acc <= '0; c_cnt <= '0; c_got_last <= 1'b0; c_lat <= 0; core_out_ready <= 1'b0;
    end else begin
      if (core_in_ready && !core_buffer_full && !c_got_last) begin
        c_acc <= {c_acc[504:0], c_acc[511:505]} ^ {478'b0, core_byte_num, core_in};
        c_cnt <= c_cnt + 1;
        if (core_is_last) begin c_got_last <= 1'b1; c_lat <= 3; end
      end
      if (c_got_last && !core_out_ready) begin
        if (c_lat == 0) core_out_ready <= 1'b1;
        else c_lat <= c_lat - 1;
      end
    end
  end

  typedef struct packed {
    int          grp;
    int          req;
    int          nw;
    logic [127:0] w;
    logic [1:0]  bnum;
    int          order;     // expected position of this message's response in its group
    int          drop_at;   // requester stops presenting after this many words (-1: never)
    int          stall_at;  // core full for 5 cycles once this many words accepted (-1: never)
  } msg_t;

  msg_t tbl[8];
  int   ntbl;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model(input int m);
    logic [511:0] a;
    logic [1:0]   bn;
    a = '0;
    for (int i = 0; i < tbl[m].nw; i++) begin
      bn = (i == tbl[m].nw - 1) ? tbl[m].bnum : 2'd0;
      a = {a[504:0], a[511:505]} ^ {478'b0, bn, tbl[m].w[32*i +: 32]};
    end
    return a ^ {32'(tbl[m].nw), 480'b0};
  endfunction

  task automatic clear_drive();
    req_valid = '0; req_data = '0; req_last = '0; req_byte_num = '0; core_buffer_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_drive();
    #4;
    chk("core_reset_in_reset", core_reset, 1);
    @(negedge clk);
    #4;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_digest", rsp_digest, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_core_in_ready", core_in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_group(input int g, input int abort_words);
    int mi[NREQ];
    int wi[NREQ];
    int last_acc[NREQ];
    bit stalled[NREQ];
    int nmsg, ndrop, nend, acc_words, rst_cycles, viol, end_iter, gap, stall_left, owner, m, extra;
    bit done;
    nmsg = 0; ndrop = 0; nend = 0; acc_words = 0; rst_cycles = 0; viol = 0;
    end_iter = 0; gap = 0; stall_left = 0; done = 1'b0; extra = 0;
    for (int r = 0; r < NREQ; r++) begin mi[r] = -1; wi[r] = 0; last_acc[r] = 0; stalled[r] = 1'b0; end
    for (int k = 0; k < ntbl; k++)
      if (tbl[k].grp == g) begin
        mi[tbl[k].req] = k; nmsg++;
        if (tbl[k].drop_at >= 0) ndrop++;
      end
    for (int it = 0; it < BUDGET && !done; it++) begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        m = mi[r];
        if (m >= 0 && wi[r] < tbl[m].nw && (tbl[m].drop_at < 0 || wi[r] < tbl[m].drop_at)) begin
          req_valid[r]         = 1'b1;
          req_data[32*r +: 32] = tbl[m].w[32*wi[r] +: 32];
          req_last[r]          = (wi[r] == tbl[m].nw - 1);
          req_byte_num[2*r +: 2] = (wi[r] == tbl[m].nw - 1) ? tbl[m].bnum : 2'd0;
        end else begin
          req_valid[r] = 1'b0; req_data[32*r +: 32] = '0; req_last[r] = 1'b0; req_byte_num[2*r +: 2] = '0;
        end
      end
      core_buffer_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #4;
      owner = -1;
      for (int r = 0; r < NREQ; r++)
        if (mi[r] >= 0 && tbl[mi[r]].order == nend) owner = r;
      if (core_buffer_full && req_ready != '0) viol++;
      for (int r = 0; r < NREQ; r++)
        if (req_ready[r] && r != owner) viol++;
      if (core_reset) rst_cycles++;
      for (int r = 0; r < NREQ; r++)
        if (req_valid[r] && req_ready[r]) begin
          if (wi[r] == 0) chk("first_word_cycle", it, (nend == 0) ? 2 : end_iter + gap);
          wi[r]++; acc_words++; last_acc[r] = it;
          if (wi[r] == tbl[mi[r]].stall_at && !stalled[r]) begin stalled[r] = 1'b1; stall_left = 5; end
        end
      if (rsp_valid) begin
        chk("rsp_id", rsp_id, owner);
        if (owner >= 0) chk("rsp_digest", rsp_digest, model(mi[owner]));
        nend++; end_iter = it; gap = 3;
      end
      if (rsp_err) begin
        chk("err_id", rsp_id, owner);
        chk("err_expected", (owner >= 0) && (tbl[mi[owner]].drop_at >= 0), 1);
        if (owner >= 0) chk("err_delay", it - last_acc[owner], TMO + 1);
        nend++; end_iter = it; gap = 2;
      end
      if ((abort_words > 0 && acc_words >= abort_words) || nend >= nmsg) done = 1'b1;
    end
    if (abort_words > 0) return;
    chk("group_complete", nend, nmsg);
    chk("ready_violations", viol, 0);
    chk("core_reset_cycles", rst_cycles, nmsg + ndrop);
    repeat (4) begin
      @(negedge clk);
      clear_drive();
      #4;
      if (rsp_valid || rsp_err) extra++;
    end
    chk("no_extra_rsp", extra, 0);
  endtask

  initial begin
    reset = 1'b0;
    clear_drive();
    ntbl = 0;
    //                grp req nw  words (word0 in low bits)                                      bnum ord drop stall
    tbl[ntbl++] = '{0, 0, 4, {32'h21000000, 32'h6f726c64, 32'h6f2c2077, 32'h48656c6c}, 2'd1, 0, -1, -1};
    tbl[ntbl++] = '{0, 1, 3, {32'h0,        32'hcafef00d, 32'h0badbeef, 32'h01234567}, 2'd3, 1, -1, -1};
    tbl[ntbl++] = '{1, 1, 3, {32'h0,        32'h0,        32'haaaa5555, 32'h12345678}, 2'd0, 0, -1, -1};
    tbl[ntbl++] = '{2, 0, 2, {64'h0,                      32'h0,        32'hdeadbeef}, 2'd0, 0, -1, -1};
    tbl[ntbl++] = '{3, 1, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 2'd2, 0, -1,  2};
    tbl[ntbl++] = '{4, 0, 4, {32'h0f0f0f0f, 32'hf0f0f0f0, 32'h13579bdf, 32'h2468ace0}, 2'd3, 0, -1, -1};
    tbl[ntbl++] = '{5, 0, 4, {32'h0f0f0f0f, 32'hf0f0f0f0, 32'h13579bdf, 32'h2468ace0}, 2'd3, 0, -1, -1};
`ifdef KECCAK_ARB_TIMEOUT_EN
    tbl[ntbl++] = '{6, 0, 4, {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666}, 2'd3, 0,  2, -1};
    tbl[ntbl++] = '{6, 1, 2, {64'h0,                      32'h5a5a5a5a, 32'ha5a5a5a5}, 2'd2, 1, -1, -1};
`endif

    do_reset();
    run_group(0, 0);   // simultaneous requests, ptr=0: req0 then req1
    run_group(1, 0);   // req1 alone, empty last word
    run_group(2, 0);   // req0 alone, empty last word
    run_group(3, 0);   // core backpressure for 5 cycles mid-stream
    run_group(4, 2);   // abandoned by reset after two words
    do_reset();
    run_group(5, 0);   // resend after reset
`ifdef KECCAK_ARB_TIMEOUT_EN
    do_reset();
    run_group(6, 0);   // req0 stalls, times out, req1 served
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
